cmd_wb_exec: RTL

- Responder end of the 34-bit host command interface (cmd_stb/cmd_word/cmd_busy/rsp_stb/rsp_word) driven by the CPU controller.
- Decodes each command word, runs at most one Wishbone pipelined-mode bus transaction, and returns exactly one response word per accepted command.
- Sits between the controller and the instruction/data memory slave.

---
 rtl/cmd_wb_exec.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cmd_wb_exec.sv
// cmd_wb_exec: executes host commands (READ/WRITE/SET_ADDR/ABORT) as single Wishbone
// pipelined-mode transactions and returns exactly one response word per accepted command.
// Optional build macro CMD_WB_TIMEOUT_EN: when defined, a bus transaction that gets no
// ack/err within TIMEOUT_CYCLES is abandoned with an error response.
`timescale 1ns / 1ps

module cmd_wb_exec #(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_stb,
  input  logic [33:0]           cmd_word,
  output logic                  cmd_busy,
  output logic                  rsp_stb,
  output logic [33:0]           rsp_word,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [31:0]           wb_data_w,
  output logic [3:0]            wb_sel,
  input  logic                  wb_stall,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  input  logic [31:0]           wb_data_r
);

  localparam logic [1:0] OpRead    = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpSetAddr = 2'b10;
  localparam logic [1:0] OpAbort   = 2'b11;

  localparam logic [1:0] RspWrite = 2'b00;
  localparam logic [1:0] RspRead  = 2'b01;
  localparam logic [1:0] RspAddr  = 2'b10;
  localparam logic [1:0] RspErr   = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                state_q;
  logic                  cmd_busy_q;
  logic                  rsp_stb_q;
  logic [33:0]           rsp_word_q;
  logic                  wb_cyc_q;
  logic                  wb_stb_q;
  logic                  wb_we_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [31:0]           wb_data_w_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inc_en_q;

  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] set_addr_val;
  logic                  timeout_hit;

  assign cmd_op = cmd_word[33:32];

  // Relative offsets wrap mod 2^ADDR_WIDTH, so sign extension reduces to a plain add.
  assign set_addr_val = cmd_word[31] ? addr_q + cmd_word[ADDR_WIDTH-1:0]
                                     : cmd_word[ADDR_WIDTH-1:0];

`ifdef CMD_WB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] tmo_cnt_q;
  logic            in_bus;

  assign in_bus      = (state_q == StReq) || (state_q == StWait);
  assign timeout_hit = in_bus && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Count edges spent in REQ/WAIT; cleared whenever no transaction is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (in_bus) begin
      tmo_cnt_q <= tmo_cnt_q + CntW'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Command FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cmd_busy_q  <= 1'b0;
      rsp_stb_q   <= 1'b0;
      rsp_word_q  <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_w_q <= '0;
      addr_q      <= '0;
      inc_en_q    <= 1'b1;
    end else begin
      rsp_stb_q <= 1'b0;
      unique case (state_q)
        // RESP behaves like IDLE for acceptance so commands can run back-to-back.
        StIdle, StResp: begin
          state_q    <= StIdle;
          cmd_busy_q <= 1'b0;
          if (cmd_stb && !cmd_busy_q) begin
            unique case (cmd_op)
              OpRead, OpWrite: begin
                state_q    <= StReq;
                cmd_busy_q <= 1'b1;
                wb_cyc_q   <= 1'b1;
                wb_stb_q   <= 1'b1;
                wb_we_q    <= (cmd_op == OpWrite);
                wb_addr_q  <= addr_q;
                if (cmd_op == OpWrite) begin
                  wb_data_w_q <= cmd_word[31:0];
                end
              end
              OpSetAddr: begin
                state_q    <= StResp;
                addr_q     <= set_addr_val;
                inc_en_q   <= ~cmd_word[30];
                rsp_stb_q  <= 1'b1;
                rsp_word_q <= {RspAddr, 32'(set_addr_val)};
              end
              OpAbort: begin
                state_q    <= StResp;
                rsp_stb_q  <= 1'b1;
                rsp_word_q <= {RspErr, 32'h0000_0000};
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        StReq, StWait: begin
          if (wb_err || wb_ack || timeout_hit) begin
            state_q    <= StResp;
            cmd_busy_q <= 1'b0;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            rsp_stb_q  <= 1'b1;
            if (wb_err || !wb_ack) begin
              // Error wins over a simultaneous ack; failed transfers never advance the address.
              rsp_word_q <= {RspErr, 32'h0000_0000};
            end else begin
              rsp_word_q <= wb_we_q ? {RspWrite, 32'h0000_0000} : {RspRead, wb_data_r};
              if (inc_en_q) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
              end
            end
          end else if ((state_q == StReq) && !wb_stall) begin
            state_q  <= StWait;
            wb_stb_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_busy  = cmd_busy_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_word  = rsp_word_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data_w = wb_data_w_q;
  assign wb_sel    = 4'hF;

endmodule
